// File: rtl/multi_phase_driver.sv
// multi_phase_driver
//   N-channel phase-locked PWM driver. All channels share one NCO phase
//   accumulator. Each channel compares its own phase-shifted copy of the
//   accumulator's top slice against a duty threshold, delays rising edges by
//   a common dead time, and applies a per-channel output polarity.
//   Settings are captured into a pending set by upd. The pending set becomes
//   active immediately when idle, or exactly at a period boundary when
//   running, so a period never mixes old and new settings.
//
// Ports
//   clk        system clock (PHY clock)
//   rst        synchronous active-high reset
//   en         run request (level)
//   freq_word  accumulator increment per clk
//   duty       per-channel high time, N_CH x PHASE_BITS, channel i at [i*PHASE_BITS +: PHASE_BITS]
//   phase      per-channel phase offset, same packing as duty
//   polarity   per-channel output inversion
//   dead_time  rising-edge delay in clk ticks, shared by all channels
//   upd        one-cycle capture strobe for all settings inputs
//   upd_ack    one-cycle pulse when the pending set becomes active
//   drv        registered driver outputs
//   running    high while in RUN or STOPPING
//   wrap       one-cycle pulse on accumulator overflow

// Per-channel slice: raw compare, dead-time gate, output register.
//   clk, rst    clock / synchronous reset
//   run         driver is in RUN or STOPPING
//   p           accumulator top slice (current phase)
//   phase,duty  active channel settings
//   pol         active channel polarity
//   dead_time   active dead time
//   drv         registered channel output
module multi_phase_driver_lane #(
  parameter int PHASE_BITS = 16,
  parameter int DT_BITS    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [PHASE_BITS-1:0] p,
  input  logic [PHASE_BITS-1:0] phase,
  input  logic [PHASE_BITS-1:0] duty,
  input  logic                  pol,
  input  logic [DT_BITS-1:0]    dead_time,
  output logic                  drv
);

  logic [PHASE_BITS-1:0] local_p;
  logic                  raw;
  logic                  raw_q;
  logic                  gate;
  logic                  gate_n;
  logic [DT_BITS-1:0]    cnt;
  logic [DT_BITS-1:0]    cnt_n;

  // Modular subtraction gives the position inside this channel's own period.
  assign local_p = p - phase;
  // Forced low while idle so the first sample after start counts as a rising edge.
  assign raw     = run && (local_p < duty);

  always_comb begin
    cnt_n  = '0;
    gate_n = 1'b0;
    if (raw) begin
      if (!raw_q) begin
        cnt_n  = dead_time;
        gate_n = (dead_time == '0);
      end else if (cnt != '0) begin
        cnt_n  = cnt - DT_BITS'(1);
        gate_n = (cnt == DT_BITS'(1));
      end else begin
        // Counter already expired during this pulse: gate stays open.
        gate_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q <= 1'b0;
      cnt   <= '0;
      gate  <= 1'b0;
      drv   <= 1'b0;
    end else begin
      raw_q <= raw;
      cnt   <= cnt_n;
      gate  <= gate_n;
      drv   <= run ? (gate ^ pol) : pol;
    end
  end

endmodule

module multi_phase_driver #(
  parameter int N_CH       = 4,
  parameter int ACC_BITS   = 32,
  parameter int PHASE_BITS = 16,
  parameter int DT_BITS    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [ACC_BITS-1:0]        freq_word,
  input  logic [N_CH*PHASE_BITS-1:0] duty,
  input  logic [N_CH*PHASE_BITS-1:0] phase,
  input  logic [N_CH-1:0]            polarity,
  input  logic [DT_BITS-1:0]         dead_time,
  input  logic                       upd,
  output logic                       upd_ack,
  output logic [N_CH-1:0]            drv,
  output logic                       running,
  output logic                       wrap
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  typedef struct packed {
    logic [ACC_BITS-1:0]                freq_word;
    logic [N_CH-1:0][PHASE_BITS-1:0]    duty;
    logic [N_CH-1:0][PHASE_BITS-1:0]    phase;
    logic [N_CH-1:0]                    polarity;
    logic [DT_BITS-1:0]                 dead_time;
  } cfg_t;

  state_t              state;
  state_t              state_n;
  cfg_t                cfg_in;
  cfg_t                act;
  cfg_t                pend;
  logic                pend_vld;
  logic [ACC_BITS-1:0] acc;
  logic [ACC_BITS:0]   sum;
  logic                run;
  logic                carry;
  logic                commit;
  logic                acc_clr;
  logic [PHASE_BITS-1:0] p;

  always_comb begin
    cfg_in           = '0;
    cfg_in.freq_word = freq_word;
    cfg_in.duty      = duty;
    cfg_in.phase     = phase;
    cfg_in.polarity  = polarity;
    cfg_in.dead_time = dead_time;
  end

  assign run     = (state != IDLE);
  assign running = run;
  assign sum     = {1'b0, acc} + {1'b0, act.freq_word};
  assign carry   = run && sum[ACC_BITS];
  // Committing on the carry edge makes the new set live for the very first
  // sample of the new period (acc just wrapped), with upd_ack aligned to wrap.
  assign commit  = pend_vld && ((state == IDLE) || carry);
  assign p       = acc[ACC_BITS-1 -: PHASE_BITS];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (en) state_n = RUN;
      RUN:      if (!en) state_n = STOPPING;
      STOPPING: begin
        if (en)
          state_n = RUN;
        // A zero increment never wraps, so do not wait for one.
        else if (wrap || (act.freq_word == '0))
          state_n = IDLE;
      end
      default:  state_n = IDLE;
    endcase
  end

  // acc sits at 0 in IDLE and on the way into it, so every start begins at phase 0.
  assign acc_clr = (state == IDLE) || (state_n == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      wrap     <= 1'b0;
      act      <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      upd_ack  <= 1'b0;
    end else begin
      state   <= state_n;
      upd_ack <= commit;
      if (acc_clr) begin
        acc  <= '0;
        wrap <= 1'b0;
      end else begin
        acc  <= sum[ACC_BITS-1:0];
        wrap <= sum[ACC_BITS];
      end
      if (commit)
        act <= pend;
      // A capture in the commit cycle wins and stays pending for the next boundary.
      if (upd) begin
        pend     <= cfg_in;
        pend_vld <= 1'b1;
      end else if (commit) begin
        pend_vld <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    multi_phase_driver_lane #(
      .PHASE_BITS (PHASE_BITS),
      .DT_BITS    (DT_BITS)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .p         (p),
      .phase     (act.phase[i]),
      .duty      (act.duty[i]),
      .pol       (act.polarity[i]),
      .dead_time (act.dead_time),
      .drv       (drv[i])
    );
  end

endmodule

// File: tb/tb_multi_phase_driver.sv
module tb_multi_phase_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        upd = 1'b0;
  logic [31:0] freq_word = '0;
  logic [63:0] duty      = '0;
  logic [63:0] phase     = '0;
  logic [3:0]  polarity  = '0;
  logic [7:0]  dead_time = '0;
  logic        upd_ack;
  logic [3:0]  drv;
  logic        running;
  logic        wrap;

  always #4 clk = ~clk;

  multi_phase_driver #(
    .N_CH(4), .ACC_BITS(32), .PHASE_BITS(16), .DT_BITS(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .freq_word (freq_word),
    .duty      (duty),
    .phase     (phase),
    .polarity  (polarity),
    .dead_time (dead_time),
    .upd       (upd),
    .upd_ack   (upd_ack),
    .drv       (drv),
    .running   (running),
    .wrap      (wrap)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_upd();
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  // Ticks until wrap is seen (at least one tick), bounded.
  task automatic wait_wrap(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!wrap && n < 200);
  endtask

  // ---------------------------------------------------------------------
  // Reference model: spec rules with plain integer arithmetic. Dead time is
  // modelled as "output open once raw has been high for more than dead_time
  // consecutive samples"; outputs trail the accumulator sample by two clocks.
  // ---------------------------------------------------------------------
  int          m_state;                 // 0 idle, 1 run, 2 stopping
  longint      m_acc, m_fw, p_fw;
  bit          m_wrap, m_ack, m_pv;
  int          m_du[4], m_ph[4], p_du[4], p_ph[4];
  bit   [3:0]  m_pol, p_pol, m_gate, m_drv;
  int          m_dt, p_dt;
  int          m_len[4];
  int          md_p, md_ns;
  bit          md_run, md_carry, md_commit;
  bit   [3:0]  md_ndrv;
  longint      md_sum;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_acc = 0; m_fw = 0; p_fw = 0;
      m_wrap = 0; m_ack = 0; m_pv = 0;
      m_pol = 0; p_pol = 0; m_gate = 0; m_drv = 0;
      m_dt = 0; p_dt = 0;
      for (int c = 0; c < 4; c++) begin
        m_du[c] = 0; m_ph[c] = 0; p_du[c] = 0; p_ph[c] = 0; m_len[c] = 0;
      end
    end else begin
      md_run = (m_state != 0);
      md_p   = int'((m_acc >> 16) & 64'hFFFF);
      for (int c = 0; c < 4; c++) begin
        md_ndrv[c] = md_run ? (m_gate[c] ^ m_pol[c]) : m_pol[c];
        if (md_run && (((md_p - m_ph[c]) & 'hFFFF) < m_du[c])) m_len[c]++;
        else m_len[c] = 0;
        m_gate[c] = (m_len[c] > m_dt);
      end
      md_sum   = m_acc + m_fw;
      md_carry = md_run && (md_sum >= 64'h1_0000_0000);
      case (m_state)
        0:       md_ns = en ? 1 : 0;
        1:       md_ns = en ? 1 : 2;
        default: md_ns = en ? 1 : ((m_wrap || m_fw == 0) ? 0 : 2);
      endcase
      md_commit = m_pv && (m_state == 0 || md_carry);
      if (m_state == 0 || md_ns == 0) begin
        m_acc = 0; m_wrap = 0;
      end else begin
        m_acc = md_sum % 64'h1_0000_0000; m_wrap = md_carry;
      end
      m_ack = md_commit;
      if (md_commit) begin
        m_fw = p_fw; m_pol = p_pol; m_dt = p_dt;
        for (int c = 0; c < 4; c++) begin m_du[c] = p_du[c]; m_ph[c] = p_ph[c]; end
      end
      if (upd) begin
        p_fw = longint'(freq_word); p_pol = polarity; p_dt = int'(dead_time); m_pv = 1;
        for (int c = 0; c < 4; c++) begin
          p_du[c] = int'(duty[c*16 +: 16]); p_ph[c] = int'(phase[c*16 +: 16]);
        end
      end else if (md_commit) begin
        m_pv = 0;
      end
      m_drv   = md_ndrv;
      m_state = md_ns;
    end
  end

  // Static-setting table: counts over one 16-clk period in steady state.
  typedef struct {
    logic [15:0] d0, p0, d1, p1;
    logic [7:0]  dt;
    logic [3:0]  pol;
    int          hi0, hi1, ovl;
  } vec_t;

  vec_t vt[7];

  int n, h0, h1, ov, wr, acks, ackw, bad;

  initial begin
    vt[0] = '{16'h8000, 16'h0000, 16'h8000, 16'h8000, 8'd0, 4'b0000,  8,  8,  0};
    vt[1] = '{16'h8000, 16'h0000, 16'h8000, 16'h8000, 8'd2, 4'b0000,  6,  6,  0};
    vt[2] = '{16'h4000, 16'h0000, 16'hC000, 16'h0000, 8'd0, 4'b0000,  4, 12,  4};
    vt[3] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 8'd0, 4'b0000,  0, 16,  0};
    vt[4] = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 8'd0, 4'b0011, 12, 16, 12};
    vt[5] = '{16'h4000, 16'h0000, 16'h8000, 16'h8000, 8'd5, 4'b0000,  0,  3,  0};
    vt[6] = '{16'h2000, 16'hF000, 16'h0000, 16'h0000, 8'd1, 4'b0000,  1,  0,  0};

    // Reset state
    tick(3);
    chk("rst_drv", drv, 0);
    chk("rst_running", running, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_ack", upd_ack, 0);
    rst = 1'b0;

    // Table-driven steady-state waveforms
    for (int v = 0; v < 7; v++) begin
      rst = 1'b1; en = 1'b0; tick(2); rst = 1'b0;
      freq_word = 32'h1000_0000;
      duty      = {32'h0, vt[v].d1, vt[v].d0};
      phase     = {32'h0, vt[v].p1, vt[v].p0};
      polarity  = vt[v].pol;
      dead_time = vt[v].dt;
      pulse_upd();
      tick(3);
      en = 1'b1;
      tick(40);
      h0 = 0; h1 = 0; ov = 0; wr = 0;
      repeat (16) begin
        h0 += int'(drv[0]); h1 += int'(drv[1]); ov += int'(drv[0] & drv[1]); wr += int'(wrap);
        tick();
      end
      chk($sformatf("tbl%0d_hi0", v), h0, vt[v].hi0);
      chk($sformatf("tbl%0d_hi1", v), h1, vt[v].hi1);
      chk($sformatf("tbl%0d_ovl", v), ov, vt[v].ovl);
      chk($sformatf("tbl%0d_wraps", v), wr, 1);
    end

    // Basic PWM: single ack while idle, 16-clk wrap period
    rst = 1'b1; en = 1'b0; tick(2); rst = 1'b0;
    freq_word = 32'h1000_0000; duty = 64'h8000; phase = '0; polarity = '0; dead_time = '0;
    upd = 1'b1; tick(); upd = 1'b0;
    acks = 0; bad = 0;
    repeat (5) begin
      acks += int'(upd_ack);
      if (upd_ack && running) bad++;
      tick();
    end
    chk("basic_ack_once", acks, 1);
    chk("basic_ack_idle", bad, 0);
    en = 1'b1;
    wait_wrap(n);
    chk("basic_wrap_seen", wrap, 1);
    wait_wrap(n);
    chk("basic_wrap_period", n, 16);

    // Boundary-aligned update: request mid-period, applied at next wrap
    tick(2);
    h0 = 0; acks = 0; ackw = 0;
    for (int i = 0; i < 16; i++) begin
      h0 += int'(drv[0]); acks += int'(upd_ack);
      if (upd_ack && wrap) ackw++;
      if (i == 1) begin duty[15:0] = 16'h4000; upd = 1'b1; end
      if (i == 2) upd = 1'b0;
      tick();
    end
    chk("bnd_cur_hi", h0, 8);
    chk("bnd_ack_cnt", acks, 1);
    chk("bnd_ack_at_wrap", ackw, 1);
    h0 = 0;
    repeat (16) begin h0 += int'(drv[0]); tick(); end
    chk("bnd_next_hi", h0, 4);

    // Controlled stop: drop en at acc step 3, period completes
    h0 = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      h0 += int'(drv[0]);
      if (running !== (i < 15)) bad++;
      if (i == 1) en = 1'b0;
      tick();
    end
    chk("stop_hi", h0, 4);
    chk("stop_running_seq", bad, 0);
    chk("stop_drv_inactive", drv, 4'b0000);
    chk("stop_running", running, 0);

    // Stop request withdrawn within the period
    en = 1'b1;
    wait_wrap(n);
    tick(2);
    h0 = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      h0 += int'(drv[0]);
      if (!running) bad++;
      if (i == 1) en = 1'b0;
      if (i == 3) en = 1'b1;
      tick();
    end
    chk("rerun_hi", h0, 4);
    chk("rerun_running", bad, 0);
    h0 = 0;
    repeat (16) begin h0 += int'(drv[0]); tick(); end
    chk("rerun_next_hi", h0, 4);
    en = 1'b0;
    tick(40);

    // Polarity while idle, duty=0 gives constant inactive level
    duty = '0; polarity = 4'b0101;
    pulse_upd();
    tick(4);
    chk("pol_idle", drv, 4'b0101);
    en = 1'b1;
    bad = 0;
    repeat (24) begin if (drv !== 4'b0101) bad++; tick(); end
    chk("duty0_inactive", bad, 0);
    en = 1'b0;
    tick(40);
    chk("pol_back_idle", running, 0);

    // freq_word=0: outputs hold in RUN, STOPPING exits in one cycle
    freq_word = '0; duty = 64'h8000; polarity = '0;
    pulse_upd();
    tick(4);
    en = 1'b1;
    tick(4);
    chk("fw0_drv", drv, 4'b0001);
    bad = 0;
    repeat (8) begin if (drv !== 4'b0001) bad++; tick(); end
    chk("fw0_hold", bad, 0);
    en = 1'b0;
    tick();
    chk("fw0_stopping", running, 1);
    tick();
    chk("fw0_idle", running, 0);

    // Reset mid-pulse
    freq_word = 32'h1000_0000; duty = 64'h8000;
    pulse_upd();
    tick(3);
    en = 1'b1;
    n = 0;
    while (drv[0] !== 1'b1 && n < 100) begin tick(); n++; end
    chk("rstmid_pulse_seen", drv[0], 1);
    rst = 1'b1;
    tick();
    chk("rstmid_drv", drv, 0);
    chk("rstmid_running", running, 0);
    chk("rstmid_wrap", wrap, 0);
    chk("rstmid_acc", dut.acc, 0);
    rst = 1'b0; en = 1'b0;

    // Randomized run against the reference model
    rst = 1'b1; tick(2); rst = 1'b0;
    dead_time = 8'd3; freq_word = 32'h1000_0000; duty = {$urandom, $urandom};
    upd = 1'b1;
    for (int i = 0; i < 900; i++) begin
      chk($sformatf("rand%0d", i), {drv, running, wrap, upd_ack},
          {m_drv, (m_state != 0), m_wrap, m_ack});
      if ($urandom_range(29) == 0) en = ~en;
      upd      = ($urandom_range(19) == 0);
      duty     = {$urandom, $urandom};
      phase    = {$urandom, $urandom};
      polarity = 4'($urandom);
      case ($urandom_range(4))
        0:       freq_word = 32'h1000_0000;
        1:       freq_word = 32'h0800_0000;
        2:       freq_word = 32'h0C00_0000;
        3:       freq_word = $urandom;
        default: freq_word = ($urandom_range(9) == 0) ? 32'h0 : 32'h1800_0000;
      endcase
      if (i == 0) en = 1'b1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
